md_unit: RTL and testbench



---
 rtl/md_unit.sv | 137 +++++++++++++
 tb/tb_md_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage, owning HI/LO.
// Results are computed at launch and committed when the busy countdown ends.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic        pend_wr, pend_wr_nxt;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, bu_div, bm_div;
    logic [31:0] q_u, r_u, q_m, r_m, q_s, r_s;

    assign state = (cnt == 4'd0) ? IDLE : RUN;
    assign busy  = (state == RUN);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes; avoids the INT_MIN/-1 overflow case.
    assign a_mag  = A[31] ? (32'd0 - A) : A;
    assign b_mag  = B[31] ? (32'd0 - B) : B;
    assign bu_div = (B == 32'd0) ? 32'd1 : B;
    assign bm_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_u    = A / bu_div;
    assign r_u    = A % bu_div;
    assign q_m    = a_mag / bm_div;
    assign r_m    = a_mag % bm_div;
    assign q_s    = (A[31] ^ B[31]) ? (32'd0 - q_m) : q_m;
    assign r_s    = A[31] ? (32'd0 - r_m) : r_m;

    always_comb begin
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        unique case (state)
            IDLE: begin
                if (start) begin
                    case (mdop)
                        OP_MULT: begin
                            pend_hi_nxt = prod_s[63:32];
                            pend_lo_nxt = prod_s[31:0];
                            pend_wr_nxt = 1'b1;
                            cnt_nxt     = MC;
                        end
                        OP_MULTU: begin
                            pend_hi_nxt = prod_u[63:32];
                            pend_lo_nxt = prod_u[31:0];
                            pend_wr_nxt = 1'b1;
                            cnt_nxt     = MC;
                        end
                        OP_DIV: begin
                            pend_hi_nxt = r_s;
                            pend_lo_nxt = q_s;
                            pend_wr_nxt = (B != 32'd0);
                            cnt_nxt     = DC;
                        end
                        OP_DIVU: begin
                            pend_hi_nxt = r_u;
                            pend_lo_nxt = q_u;
                            pend_wr_nxt = (B != 32'd0);
                            cnt_nxt     = DC;
                        end
                        OP_MTHI: hi_nxt = A;
                        OP_MTLO: lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1 && pend_wr) begin
                    hi_nxt = pend_hi;
                    lo_nxt = pend_lo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
        end
    end

    always_comb begin
        md_out = 32'd0;
        if (mdop == OP_MFHI) md_out = hi;
        else if (mdop == OP_MFLO) md_out = lo;
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table, corner sequences and randomized run
// against an arithmetic reference model of HI/LO.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] md_out, hi, lo;

    int checks = 0;
    int fails  = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop),
        .A(A), .B(B), .busy(busy), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ebusy;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] m_hi, m_lo;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch at one edge, then count busy cycles sampled on falling edges.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int nb);
        @(negedge clk);
        start = 1'b1; mdop = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; mdop = 4'd0;
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
    endtask

    function automatic int model_busy(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
        return 0;
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint      la, lb, p, q, r;
        logic [63:0] pu;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (op)
            4'd1: begin
                p = la * lb;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            4'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                m_hi = pu[63:32]; m_lo = pu[31:0];
            end
            4'd3: if (b != 0) begin
                q = la / lb; r = la % lb;
                m_hi = r[31:0]; m_lo = q[31:0];
            end
            4'd4: if (b != 0) begin
                m_hi = a % b; m_lo = a / b;
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic chk_reads(input string tag, input logic [31:0] eh,
                             input logic [31:0] el);
        mdop = 4'd5; #1;
        chk({tag, " mfhi"}, md_out, eh);
        mdop = 4'd6; #1;
        chk({tag, " mflo"}, md_out, el);
        mdop = 4'd0; #1;
        chk({tag, " md_out idle"}, md_out, 32'd0);
    endtask

    initial begin
        int nb;
        reset = 1'b0; start = 1'b0; mdop = 4'd0; A = 0; B = 0;

        vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10};
        vecs[4] = '{4'd7, 32'h11, 32'd0, 32'h11, 32'd3, 0};
        vecs[5] = '{4'd8, 32'h22, 32'd0, 32'h11, 32'h22, 0};
        vecs[6] = '{4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10};
        vecs[7] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10};
        vecs[8] = '{4'd0, 32'h1234, 32'd1, 32'd0, 32'h80000000, 0};
        vecs[9] = '{4'd12, 32'h5678, 32'd3, 32'd0, 32'h80000000, 0};

        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            chk($sformatf("vec%0d busy", i), nb, vecs[i].ebusy);
            chk($sformatf("vec%0d hi", i), hi, vecs[i].ehi);
            chk($sformatf("vec%0d lo", i), lo, vecs[i].elo);
            chk_reads($sformatf("vec%0d", i), vecs[i].ehi, vecs[i].elo);
        end

        // start during busy must be ignored for both mthi and mult
        @(negedge clk);
        start = 1'b1; mdop = 4'd1; A = 32'd3; B = 32'd4;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) nb++;
            start = 1'b0; mdop = 4'd0;
            if (k == 0) begin start = 1'b1; mdop = 4'd7; A = 32'hDEAD; end
            if (k == 2) begin start = 1'b1; mdop = 4'd1; A = 9; B = 9; end
        end
        chk("ignored busy len", nb, 5);
        chk("ignored hi", hi, 32'd0);
        chk("ignored lo", lo, 32'd12);

        // reset on the 4th busy cycle of a divide aborts it
        @(negedge clk);
        start = 1'b1; mdop = 4'd4; A = 32'd100; B = 32'd7;
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0; mdop = 4'd0;
            if (busy) nb++;
            if (nb == 4 && reset) reset = 1'b0;
            else reset = 1'b1;
        end
        chk("rst mid busy cnt", nb, 4);
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        chk("rst mid hi", hi, 32'd0);
        chk("rst mid lo", lo, 32'd0);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst late busy", {31'd0, busy}, 32'd0);
        chk("rst late hi", hi, 32'd0);
        chk("rst late lo", lo, 32'd0);

        // randomized sequence against the arithmetic model
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            if (op > 4'd8 && $urandom_range(0, 3) != 0)
                op = 4'($urandom_range(1, 8));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'h80000000;
                default: ;
            endcase
            do_op(op, a, b, nb);
            model(op, a, b);
            chk($sformatf("rnd%0d op%0d busy", i, op), nb, model_busy(op));
            chk($sformatf("rnd%0d op%0d hi", i, op), hi, m_hi);
            chk($sformatf("rnd%0d op%0d lo", i, op), lo, m_lo);
            if (i % 10 == 0) chk_reads($sformatf("rnd%0d", i), m_hi, m_lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
